axi4_burst_slave_mem: RTL
=========================

Name: axi4_burst_slave_mem

Overview:
- AXI4 (full) memory-mapped slave that responds to burst-capable masters such as the AXI VIP master used by the device benches.
- Holds a small register-based word memory.
- Accepts one write or one read burst at a time, with INCR, FIXED and WRAP support.
- Serves as the responder end of master-side burst write/read traffic, and as the data window for sub-devices that need burst access.

Parameters:
- C_S_AXI_ID_WIDTH, 1, width of AWID/BID/ARID/RID
- C_S_AXI_DATA_WIDTH, 32, data width (only 32 supported)
- C_S_AXI_ADDR_WIDTH, 8, byte address width
- MEM_WORDS_LOG2, 4, memory depth = 2**MEM_WORDS_LOG2 words of 32 bit

Ports:
- ACLK  in  1  clock
- ARESET  in  1  reset, asynchronous, active-high
- S_AXI_AWID  in  ID_W  write ID
- S_AXI_AWADDR  in  ADDR_W  write start address
- S_AXI_AWLEN  in  8  beats-1
- S_AXI_AWSIZE  in  3  beat size
- S_AXI_AWBURST  in  2  burst type
- S_AXI_AWVALID  in  1;  S_AXI_AWREADY  out  1
- S_AXI_WDATA  in  32;  S_AXI_WSTRB  in  4;  S_AXI_WLAST  in  1
- S_AXI_WVALID  in  1;  S_AXI_WREADY  out  1
- S_AXI_BID  out  ID_W;  S_AXI_BRESP  out  2
- S_AXI_BVALID  out  1;  S_AXI_BREADY  in  1
- S_AXI_ARID  in  ID_W;  S_AXI_ARADDR  in  ADDR_W;  S_AXI_ARLEN  in  8
- S_AXI_ARSIZE  in  3;  S_AXI_ARBURST  in  2
- S_AXI_ARVALID  in  1;  S_AXI_ARREADY  out  1
- S_AXI_RID  out  ID_W;  S_AXI_RDATA  out  32;  S_AXI_RRESP  out  2;  S_AXI_RLAST  out  1
- S_AXI_RVALID  out  1;  S_AXI_RREADY  in  1
- LOCK/CACHE/PROT/QOS/REGION/USER signals are not ports; the wrapper leaves them unconnected.

Behaviour:
- Reset (async, ARESET=1):
  - FSM goes to IDLE.
  - All READY/VALID outputs, RLAST, BRESP, RRESP, BID, RID and RDATA are 0.
  - Memory is cleared to 0.
  - Arbitration priority is set to write.
  - Reset mid-burst abandons the burst; no response is issued after reset is released.
- FSM states: IDLE, WADDR, WDATA, WRESP, RADDR, RDATA.
- IDLE arbitration:
  - AWVALID only -> WADDR; ARVALID only -> RADDR.
  - Both valid -> the side holding priority wins, and priority then toggles to the other side.
- WADDR: AWREADY=1 for exactly one cycle, one cycle after AWVALID is seen in IDLE.
  - On handshake, latch ID, addr, len, size and burst, clear the beat counter, then go to WDATA.
- WDATA: WREADY=1 continuously.
  - Each W handshake writes the bytes enabled by WSTRB at the current word and advances the address.
  - After len+1 beats -> WRESP.
  - WREADY drops in the cycle after the final beat.
- WLAST mismatch: WLAST=1 on a non-final beat, or WLAST=0 on the final beat -> BRESP=SLVERR. Data is still written and the beat count governs termination.
- WRESP: BVALID=1 with BID=latched AWID, held until BREADY. On handshake -> IDLE.
- RADDR: ARREADY pulse with the same rules as AWREADY -> RDATA.
- RDATA timing:
  - RVALID rises the cycle after the AR handshake, with RDATA = mem[start word].
  - RVALID stays high; on each RREADY handshake the next beat's data appears the following cycle (one beat/cycle at full throughput).
  - RLAST=1 only on beat len+1.
  - RID = latched ARID.
  - RDATA is stable while RVALID=1 and RREADY=0.
  - After the last handshake -> IDLE.
- Address generation (word index = addr[2+MEM_WORDS_LOG2-1:2]; higher bits ignored, so the index wraps modulo depth):
  - FIXED: address constant.
  - INCR: +4 per beat.
  - WRAP: +4, wrapping within a (len+1)*4-byte aligned window.
  - Burst type 2'b11 is treated as INCR.
- Error response (SLVERR on every R beat / on B):
  - AxSIZE != 2.
  - WRAP with len not in {1,3,7,15}; that burst proceeds as INCR.
  - Write with SLVERR from size still performs the strobed writes.
- Otherwise BRESP/RRESP=OKAY.
- Only one transaction is outstanding at any time. AWREADY/ARREADY stay 0 outside WADDR/RADDR.

Test Plan:
- INCR write of len=7, size=2, addr 0, data 1..8, WSTRB=F, then INCR read of the same -> BRESP=OKAY; read returns 1..8 with RLAST only on beat 8; first RVALID 1 cycle after the AR handshake.
- Write 0xAABBCCDD to word 2, then a single-beat write 0x11223344 with WSTRB=0101 -> read word 2 = 0xAA22CC44.
- WRAP read len=3 at addr 0x08 after writing words 0..3 = 10,11,12,13 -> beats 12,13,10,11, RRESP=OKAY.
- AWVALID and ARVALID asserted in the same cycle twice in succession -> first the write is served, then the read; at the third collision the write is served again.
- Write with WLAST asserted on beat 3 of len=7 -> 8 beats accepted, BRESP=SLVERR(2'b10). Read with RREADY toggling 1/0 -> RDATA is held while stalled.
- ARESET pulsed during beat 4 of a read burst -> RVALID=0 immediately; memory reads back 0; the next write/read pair completes normally.

Source files
------------

// File: rtl/axi4_burst_slave_mem.sv
// axi4_burst_slave_mem: AXI4 burst slave (INCR/FIXED/WRAP) backed by a small register word memory
module axi4_burst_slave_mem #(
  parameter int C_S_AXI_ID_WIDTH   = 1,
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 8,
  parameter int MEM_WORDS_LOG2     = 4
) (
  input  logic                            ACLK,
  input  logic                            ARESET,
  input  logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_AWID,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [7:0]                      S_AXI_AWLEN,
  input  logic [2:0]                      S_AXI_AWSIZE,
  input  logic [1:0]                      S_AXI_AWBURST,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WLAST,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_BID,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_ARID,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [7:0]                      S_AXI_ARLEN,
  input  logic [2:0]                      S_AXI_ARSIZE,
  input  logic [1:0]                      S_AXI_ARBURST,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_RID,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RLAST,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY
);
  localparam int IW = C_S_AXI_ID_WIDTH;
  localparam int AW = C_S_AXI_ADDR_WIDTH;
  localparam int DW = C_S_AXI_DATA_WIDTH;
  typedef enum logic [2:0] {IDLE, WADDR, WDATA, WRESP, RADDR, RDATA} state_t;
  state_t state_q, state_d;
  logic prio_w_q, prio_w_d;
  logic [IW-1:0] id_q, id_d;
  logic [AW-1:0] addr_q, addr_d, addr_nxt, wmask;
  logic [7:0] len_q, len_d, cnt_q, cnt_d;
  logic [1:0] burst_q, burst_d;
  logic err_q, err_d;
  logic [DW-1:0] mem_q [2**MEM_WORDS_LOG2];
  logic [MEM_WORDS_LOG2-1:0] widx;
  logic last, is_w, ax_valid, wrap_ok;
  logic [IW-1:0] ax_id;
  logic [AW-1:0] ax_addr;
  logic [7:0] ax_len;
  logic [2:0] ax_size;
  logic [1:0] ax_burst;
  assign is_w     = state_q == WADDR;
  assign ax_valid = is_w ? S_AXI_AWVALID : S_AXI_ARVALID;
  assign ax_id    = is_w ? S_AXI_AWID : S_AXI_ARID;
  assign ax_addr  = is_w ? S_AXI_AWADDR : S_AXI_ARADDR;
  assign ax_len   = is_w ? S_AXI_AWLEN : S_AXI_ARLEN;
  assign ax_size  = is_w ? S_AXI_AWSIZE : S_AXI_ARSIZE;
  assign ax_burst = is_w ? S_AXI_AWBURST : S_AXI_ARBURST;
  assign wrap_ok  = ax_len inside {8'd1, 8'd3, 8'd7, 8'd15};
  assign widx     = addr_q[MEM_WORDS_LOG2+1:2];
  assign last     = cnt_q == len_q;
  // burst_q holds the effective type: 0 FIXED, 1 INCR, 2 legal WRAP
  assign wmask    = AW'({len_q, 2'b11});
  assign addr_nxt = burst_q == 2'b00 ? addr_q :
                    burst_q == 2'b10 ? (addr_q & ~wmask) | ((addr_q + AW'(4)) & wmask) :
                    addr_q + AW'(4);
  always_comb begin
    state_d = state_q;
    prio_w_d = prio_w_q;
    id_d = id_q;
    addr_d = addr_q;
    len_d = len_q;
    cnt_d = cnt_q;
    burst_d = burst_q;
    err_d = err_q;
    S_AXI_AWREADY = 1'b0;
    S_AXI_ARREADY = 1'b0;
    S_AXI_WREADY = 1'b0;
    S_AXI_BVALID = 1'b0;
    S_AXI_BID = '0;
    S_AXI_BRESP = 2'b00;
    S_AXI_RVALID = 1'b0;
    S_AXI_RID = '0;
    S_AXI_RDATA = '0;
    S_AXI_RRESP = 2'b00;
    S_AXI_RLAST = 1'b0;
    case (state_q)
      IDLE:
        if (S_AXI_AWVALID && (!S_AXI_ARVALID || prio_w_q)) begin
          state_d = WADDR;
          prio_w_d = S_AXI_ARVALID ? 1'b0 : prio_w_q;
        end else if (S_AXI_ARVALID) begin
          state_d = RADDR;
          prio_w_d = S_AXI_AWVALID ? 1'b1 : prio_w_q;
        end
      WADDR, RADDR: begin
        S_AXI_AWREADY = is_w;
        S_AXI_ARREADY = !is_w;
        if (ax_valid) begin
          state_d = is_w ? WDATA : RDATA;
          id_d = ax_id;
          addr_d = ax_addr;
          len_d = ax_len;
          cnt_d = '0;
          burst_d = ax_burst == 2'b00 ? 2'b00 : (ax_burst == 2'b10 && wrap_ok) ? 2'b10 : 2'b01;
          err_d = ax_size != 3'd2 || (ax_burst == 2'b10 && !wrap_ok);
        end
      end
      WDATA: begin
        S_AXI_WREADY = 1'b1;
        if (S_AXI_WVALID) begin
          addr_d = addr_nxt;
          cnt_d = cnt_q + 8'd1;
          err_d = err_q || (S_AXI_WLAST != last);
          state_d = last ? WRESP : WDATA;
        end
      end
      WRESP: begin
        S_AXI_BVALID = 1'b1;
        S_AXI_BID = id_q;
        S_AXI_BRESP = err_q ? 2'b10 : 2'b00;
        state_d = S_AXI_BREADY ? IDLE : WRESP;
      end
      RDATA: begin
        S_AXI_RVALID = 1'b1;
        S_AXI_RID = id_q;
        S_AXI_RDATA = mem_q[widx];
        S_AXI_RRESP = err_q ? 2'b10 : 2'b00;
        S_AXI_RLAST = last;
        if (S_AXI_RREADY) begin
          addr_d = addr_nxt;
          cnt_d = cnt_q + 8'd1;
          state_d = last ? IDLE : RDATA;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge ACLK or posedge ARESET)
    if (ARESET) begin
      state_q <= IDLE;
      prio_w_q <= 1'b1;
      id_q <= '0;
      addr_q <= '0;
      len_q <= '0;
      cnt_q <= '0;
      burst_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      prio_w_q <= prio_w_d;
      id_q <= id_d;
      addr_q <= addr_d;
      len_q <= len_d;
      cnt_q <= cnt_d;
      burst_q <= burst_d;
      err_q <= err_d;
    end
  always_ff @(posedge ACLK or posedge ARESET)
    if (ARESET) begin
      for (int i = 0; i < 2**MEM_WORDS_LOG2; i++) mem_q[i] <= '0;
    end else if (state_q == WDATA && S_AXI_WVALID) begin
      for (int b = 0; b < DW/8; b++)
        if (S_AXI_WSTRB[b]) mem_q[widx][8*b +: 8] <= S_AXI_WDATA[8*b +: 8];
    end
endmodule
